// File: rtl/diff_accum_unit.sv
// diff_accum_unit: running-sum integrator y[n] = y[n-1] + d[n] that rebuilds
// samples from signed differences. Valid/ready on both sides. A 2-entry skid
// buffer keeps o_ready driven purely from registered state.
// Build option: define SATURATE_EN to clamp the sum to the DATA_W signed range
// and flag clipped beats on o_sat. Otherwise the sum wraps and o_sat stays 0.
module diff_accum_unit #(
    parameter int DATA_W = 24
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic signed [DATA_W:0]   i_d,
    input  logic                     i_clear,
    output logic signed [DATA_W-1:0] o_y,
    output logic                     o_sat,
    output logic                     o_valid,
    input  logic                     i_ready
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic signed [DATA_W-1:0] acc_q, acc_d;
    logic signed [DATA_W-1:0] out_y_q, out_y_d;
    logic                     out_sat_q, out_sat_d;
    logic signed [DATA_W-1:0] skid_y_q, skid_y_d;
    logic                     skid_sat_q, skid_sat_d;

    logic                     accept, send;
    logic signed [DATA_W+1:0] sum;
    logic signed [DATA_W-1:0] r;
    logic                     r_sat;

    // Sum in DATA_W+2 bits, which is wide enough that it can never overflow internally
    always_comb begin
        sum = (i_clear ? '0 : {{2{acc_q[DATA_W-1]}}, acc_q}) + {i_d[DATA_W], i_d};
    end

`ifdef SATURATE_EN
    localparam logic signed [DATA_W+1:0] SUM_MAX = {3'b000, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W+1:0] SUM_MIN = {3'b111, {(DATA_W-1){1'b0}}};

    // Clamp the wide sum to the nearest representable bound
    always_comb begin
        r     = sum[DATA_W-1:0];
        r_sat = 1'b0;
        if (sum > SUM_MAX) begin
            r     = {1'b0, {(DATA_W-1){1'b1}}};
            r_sat = 1'b1;
        end else if (sum < SUM_MIN) begin
            r     = {1'b1, {(DATA_W-1){1'b0}}};
            r_sat = 1'b1;
        end
    end
`else
    logic sum_unused;
    assign sum_unused = ^sum[DATA_W+1:DATA_W];

    // Two's-complement wrap, so the round trip with a wrapping difference stage stays exact
    always_comb begin
        r     = sum[DATA_W-1:0];
        r_sat = 1'b0;
    end
`endif

    assign o_ready = (state_q != FULL);
    assign o_valid = (state_q != EMPTY);
    assign o_y     = out_y_q;
    assign o_sat   = out_sat_q;
    assign accept  = i_valid && o_ready;
    assign send    = o_valid && i_ready;

    // Next-state logic for the accumulator, the output register and the skid register
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        out_y_d    = out_y_q;
        out_sat_d  = out_sat_q;
        skid_y_d   = skid_y_q;
        skid_sat_d = skid_sat_q;

        if (accept) begin
            acc_d = r;
        end

        case (state_q)
            EMPTY: begin
                if (accept) begin
                    out_y_d   = r;
                    out_sat_d = r_sat;
                    state_d   = ONE;
                end
            end
            ONE: begin
                if (accept && send) begin
                    out_y_d   = r;
                    out_sat_d = r_sat;
                end else if (accept) begin
                    skid_y_d   = r;
                    skid_sat_d = r_sat;
                    state_d    = FULL;
                end else if (send) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (send) begin
                    out_y_d   = skid_y_q;
                    out_sat_d = skid_sat_q;
                    state_d   = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= EMPTY;
            acc_q      <= '0;
            out_y_q    <= '0;
            out_sat_q  <= 1'b0;
            skid_y_q   <= '0;
            skid_sat_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            out_y_q    <= out_y_d;
            out_sat_q  <= out_sat_d;
            skid_y_q   <= skid_y_d;
            skid_sat_q <= skid_sat_d;
        end
    end

endmodule

// File: tb/tb_diff_accum_unit.sv
// Testbench for diff_accum_unit (DATA_W=8): behavioural queue/prefix-sum model
// compared every cycle, plus directed literal expectations and a random phase.
module tb_diff_accum_unit;

    localparam int W = 8;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                i_valid = 1'b0;
    logic                o_ready;
    logic signed [W:0]   i_d = '0;
    logic                i_clear = 1'b0;
    logic signed [W-1:0] o_y;
    logic                o_sat;
    logic                o_valid;
    logic                i_ready = 1'b0;

    diff_accum_unit #(.DATA_W(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_d     (i_d),
        .i_clear (i_clear),
        .o_y     (o_y),
        .o_sat   (o_sat),
        .o_valid (o_valid),
        .i_ready (i_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: accumulator value and FIFO of beats not yet sent
    int m_acc = 0;
    int m_qy[$];
    bit m_qs[$];
    // Log of beats actually delivered downstream
    int sent_y[$];
    bit sent_s[$];
    int accepted = 0;

    bit stall_prev = 1'b0;
    int prev_y = 0;
    bit prev_s = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_beat(input int d, input bit clr, output int y, output bit s);
        int sum;
        sum = (clr ? 0 : m_acc) + d;
`ifdef SATURATE_EN
        if (sum > 127) begin
            y = 127; s = 1'b1;
        end else if (sum < -128) begin
            y = -128; s = 1'b1;
        end else begin
            y = sum; s = 1'b0;
        end
`else
        y = ((sum + 128) & 255) - 128;
        s = 1'b0;
`endif
    endfunction

    // Compare DUT outputs to the model, then advance the model for the coming edge
    always @(negedge clk) begin
        if (chk_en) begin
            int y;
            bit s;
            bit acc_now, snd_now;
            chk("o_valid", int'(o_valid), int'(m_qy.size() > 0));
            chk("o_ready", int'(o_ready), int'(m_qy.size() < 2));
            if (m_qy.size() > 0) begin
                chk("o_y", int'(o_y), m_qy[0]);
                chk("o_sat", int'(o_sat), int'(m_qs[0]));
            end
            if (stall_prev) begin
                chk("stall_y", int'(o_y), prev_y);
                chk("stall_sat", int'(o_sat), int'(prev_s));
            end
            if (reset) begin
                m_qy.delete();
                m_qs.delete();
                m_acc = 0;
                stall_prev = 1'b0;
            end else begin
                snd_now = (m_qy.size() > 0) && i_ready;
                acc_now = i_valid && (m_qy.size() < 2);
                stall_prev = (m_qy.size() > 0) && !i_ready;
                prev_y = int'(o_y);
                prev_s = o_sat;
                if (snd_now) begin
                    sent_y.push_back(int'(o_y));
                    sent_s.push_back(o_sat);
                    void'(m_qy.pop_front());
                    void'(m_qs.pop_front());
                end
                if (acc_now) begin
                    model_beat(int'(i_d), i_clear, y, s);
                    m_acc = y;
                    m_qy.push_back(y);
                    m_qs.push_back(s);
                    accepted++;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present a beat and hold it until the DUT accepts it (bounded wait)
    task automatic push(input int d, input bit clr);
        int n;
        bit took;
        n = 0;
        took = 1'b0;
        i_valid = 1'b1;
        i_d = 9'(d);
        i_clear = clr;
        while (!took && n < 200) begin
            @(negedge clk);
            took = o_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!took) begin
            errors++;
            $display("FAIL push_timeout actual=%0d expected=%0d", n, 200);
        end
        i_valid = 1'b0;
        i_clear = 1'b0;
    endtask

    task automatic clear_log();
        sent_y.delete();
        sent_s.delete();
    endtask

    initial begin
        // Reset
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        idle(1);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_ready", int'(o_ready), 1);
        chk("rst_y", int'(o_y), 0);
        chk("rst_sat", int'(o_sat), 0);
        @(posedge clk);
        #1;

        // 1: basic running sum at full throughput
        i_ready = 1'b1;
        clear_log();
        push(5, 0);
        @(negedge clk);
        chk("t1_lat_valid", int'(o_valid), 1);
        chk("t1_lat_y", int'(o_y), 5);
        @(posedge clk);
        #1;
        push(3, 0);
        push(-10, 0);
        idle(3);
        chk("t1_n", sent_y.size(), 3);
        chk("t1_y0", sent_y[0], 5);
        chk("t1_y1", sent_y[1], 8);
        chk("t1_y2", sent_y[2], -2);

        // 2: backpressure fills the skid, third beat held
        clear_log();
        i_ready = 1'b0;
        push(1, 0);
        push(2, 0);
        @(negedge clk);
        chk("t2_full_ready", int'(o_ready), 0);
        @(posedge clk);
        #1;
        i_valid = 1'b1;
        i_d = 9'(4);
        idle(3);
        chk("t2_held_n", sent_y.size(), 0);
        i_ready = 1'b1;
        push(4, 0);
        idle(4);
        chk("t2_n", sent_y.size(), 3);
        chk("t2_y0", sent_y[0], -1);
        chk("t2_y1", sent_y[1], 1);
        chk("t2_y2", sent_y[2], 5);

        // 3: overflow in both directions
        clear_log();
        push(120, 1);
        push(20, 0);
        push(-120, 1);
        push(-20, 0);
        idle(3);
        chk("t3_n", sent_y.size(), 4);
`ifdef SATURATE_EN
        chk("t3_pos_y", sent_y[1], 127);
        chk("t3_pos_sat", int'(sent_s[1]), 1);
        chk("t3_neg_y", sent_y[3], -128);
        chk("t3_neg_sat", int'(sent_s[3]), 1);
`else
        chk("t3_pos_y", sent_y[1], -116);
        chk("t3_pos_sat", int'(sent_s[1]), 0);
        chk("t3_neg_y", sent_y[3], 116);
        chk("t3_neg_sat", int'(sent_s[3]), 0);
`endif

        // 4: clear semantics
        clear_log();
        push(50, 1);
        push(7, 1);
        push(1, 0);
        i_clear = 1'b1;
        idle(2);
        i_clear = 1'b0;
        push(0, 0);
        push(0, 1);
        idle(3);
        chk("t4_n", sent_y.size(), 5);
        chk("t4_clr", sent_y[1], 7);
        chk("t4_next", sent_y[2], 8);
        chk("t4_noacc_clr", sent_y[3], 8);
        chk("t4_clr_zero", sent_y[4], 0);

        // 5: reset while FULL
        i_ready = 1'b0;
        push(9, 0);
        push(9, 0);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        @(negedge clk);
        chk("t5_valid", int'(o_valid), 0);
        chk("t5_ready", int'(o_ready), 1);
        @(posedge clk);
        #1;
        clear_log();
        i_ready = 1'b1;
        push(4, 0);
        idle(2);
        chk("t5_n", sent_y.size(), 1);
        chk("t5_y", sent_y[0], 4);

        // 6: random traffic against the model
        accepted = 0;
        for (int c = 0; c < 25000; c++) begin
            i_valid = ($urandom_range(0, 3) != 0);
            i_d = 9'($urandom);
            i_clear = ($urandom_range(0, 31) == 0);
            i_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        i_clear = 1'b0;
        i_ready = 1'b1;
        idle(4);
        chk("t6_beats_ge_10k", int'(accepted >= 10000), 1);
        chk("t6_drained", int'(o_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
